// File: rtl/layer_activation_requant.sv
// Requantises an upstream layer's packed pre-activations one row per clock:
// arithmetic shift, optional ReLU, saturation, then holds the packed result for the next layer.
module layer_activation_requant #(
  parameter int unsigned rows      = 4,
  parameter int unsigned datawidth = 4,
  parameter int unsigned shift     = 2,
  parameter bit          relu_en   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_overall,
  input  logic [rows*2*datawidth-1:0]   in_data,
  input  logic                          in_done,
  input  logic                          next_done,
  output logic [rows*datawidth-1:0]     out_values,
  output logic                          out_valid,
  output logic                          next_en,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned XWidth   = 2 * datawidth;
  localparam int unsigned IdxWidth = (rows > 1) ? $clog2(rows) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(rows - 1);

  localparam logic signed [XWidth-1:0] SatMax = {{(datawidth + 1){1'b0}}, {(datawidth - 1){1'b1}}};
  localparam logic signed [XWidth-1:0] SatMin = {{(datawidth + 1){1'b1}}, {(datawidth - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StProcess, StHold} state_e;

  state_e                   state_q;
  logic [rows*XWidth-1:0]   buffer_q;
  logic [IdxWidth-1:0]      idx_q;
  logic                     in_done_q;
  logic                     done_rise;
  logic signed [XWidth-1:0] row_x;
  logic signed [XWidth-1:0] shifted;
  logic [datawidth-1:0]     row_y;

  assign done_rise = in_done & ~in_done_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    row_x = '0;
    for (int unsigned i = 0; i < rows; i++) begin
      if (idx_q == IdxWidth'(i)) row_x = buffer_q[(rows-1-i)*XWidth +: XWidth];
    end
  end

  // Shift rounds toward -inf; clamp afterwards so large magnitudes never wrap.
  always_comb begin
    shifted = row_x >>> shift;
    if (relu_en && (shifted < 0)) shifted = '0;
    if (shifted > SatMax) begin
      row_y = SatMax[datawidth-1:0];
    end else if (shifted < SatMin) begin
      row_y = SatMin[datawidth-1:0];
    end else begin
      row_y = shifted[datawidth-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state_q    <= StIdle;
      buffer_q   <= '0;
      idx_q      <= '0;
      in_done_q  <= 1'b0;
      out_values <= '0;
      out_valid  <= 1'b0;
      next_en    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      in_done_q <= in_done;
      case (state_q)
        StIdle: begin
          if (done_rise) begin
            buffer_q  <= in_data;
            out_valid <= 1'b0;
            idx_q     <= '0;
            state_q   <= StProcess;
          end
        end
        StProcess: begin
          for (int unsigned i = 0; i < rows; i++) begin
            if (idx_q == IdxWidth'(i)) out_values[(rows-1-i)*datawidth +: datawidth] <= row_y;
          end
          if (idx_q == LastIdx) begin
            idx_q     <= '0;
            out_valid <= 1'b1;
            next_en   <= 1'b1;
            state_q   <= StHold;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
          if (done_rise) overrun <= 1'b1;
        end
        StHold: begin
          // A capture edge coinciding with the acknowledge is still dropped.
          if (done_rise) overrun <= 1'b1;
          if (next_done) begin
            next_en   <= 1'b0;
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_activation_requant.sv
// Scoreboard bench: three parameterisations driven in lockstep, expected rows from a behavioural model.
module tb_layer_activation_requant;

  logic        clk = 1'b0;
  logic        rst_overall;
  logic [31:0] in_data;
  logic        in_done;
  logic        next_done;

  logic [15:0] val_a, val_b, val_c;
  logic        valid_a, valid_b, valid_c;
  logic        en_a, en_b, en_c;
  logic        busy_a, busy_b, busy_c;
  logic        ovr_a, ovr_b, ovr_c;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] q_c[$];
  logic [15:0] last_a;

  always #5 clk = ~clk;

  layer_activation_requant #(.rows(4), .datawidth(4), .shift(2), .relu_en(1'b1)) dut_a (
    .clk(clk), .rst_overall(rst_overall), .in_data(in_data), .in_done(in_done),
    .next_done(next_done), .out_values(val_a), .out_valid(valid_a), .next_en(en_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  layer_activation_requant #(.rows(4), .datawidth(4), .shift(2), .relu_en(1'b0)) dut_b (
    .clk(clk), .rst_overall(rst_overall), .in_data(in_data), .in_done(in_done),
    .next_done(next_done), .out_values(val_b), .out_valid(valid_b), .next_en(en_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  layer_activation_requant #(.rows(4), .datawidth(4), .shift(0), .relu_en(1'b0)) dut_c (
    .clk(clk), .rst_overall(rst_overall), .in_data(in_data), .in_done(in_done),
    .next_done(next_done), .out_values(val_c), .out_valid(valid_c), .next_en(en_c),
    .busy(busy_c), .overrun(ovr_c)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] conv(input logic [7:0] x, input int sh, input bit relu);
    int s;
    s = {{24{x[7]}}, x};
    s = s >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 7) s = 7;
    if (s < -8) s = -8;
    return s[3:0];
  endfunction

  function automatic logic [15:0] model(input logic [31:0] d, input int sh, input bit relu);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[(3-i)*4 +: 4] = conv(d[(3-i)*8 +: 8], sh, relu);
    return r;
  endfunction

  task automatic start_txn(input logic [31:0] d, input bit keep_done, input bit mid_pulse);
    logic [15:0] prev;
    logic [15:0] exp_a;
    int cnt;
    prev    = val_a;
    in_data = d;
    in_done = 1'b1;
    q_a.push_back(model(d, 2, 1'b1));
    q_b.push_back(model(d, 2, 1'b0));
    q_c.push_back(model(d, 0, 1'b0));
    exp_a = model(d, 2, 1'b1);
    @(negedge clk);
    check_value("capture_busy", {busy_a, busy_b, busy_c, valid_a}, 4'b1110);
    if (!keep_done) in_done = 1'b0;
    cnt = 0;
    while (cnt < 16) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check_value("slot0_only", val_a, {exp_a[15:12], prev[11:0]});
        if (mid_pulse) begin
          in_done = 1'b1;
          in_data = ~d;
        end
      end
      if (cnt == 2 && mid_pulse) in_done = 1'b0;
      if (valid_a) break;
    end
    check_value("latency", cnt, 4);
    check_value("next_en", {en_a, en_b, en_c, valid_b, valid_c}, 5'b11111);
    last_a = q_a[0];
    check_value("val_relu_sh2", val_a, q_a.pop_front());
    check_value("val_sh2", val_b, q_b.pop_front());
    check_value("val_sh0", val_c, q_c.pop_front());
  endtask

  task automatic release_hold();
    next_done = 1'b1;
    @(negedge clk);
    next_done = 1'b0;
    check_value("release", {valid_a, en_a, busy_a, valid_c, en_c, busy_c}, 6'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_overall = 1'b1;
    in_done     = 1'b0;
    next_done   = 1'b0;
    in_data     = '0;
    last_a      = '0;
    repeat (2) @(negedge clk);
    check_value("reset_vals", {val_a, val_b}, 32'h0);
    check_value("reset_flags", {valid_a, en_a, busy_a, ovr_a, valid_b, en_b, busy_b, ovr_b,
                                valid_c, en_c, busy_c, ovr_c, val_c}, 0);
    rst_overall = 1'b0;
    @(negedge clk);

    // {57,-20,12,-128}: relu 7030, no relu 7B38
    start_txn(32'h39EC0C80, 1'b0, 1'b0);
    check_value("t1_const", val_a, 16'h7030);
    check_value("t2_const", val_b, 16'h7B38);
    repeat (10) begin
      @(negedge clk);
      check_value("hold_stable", {valid_a, en_a, val_a}, {2'b11, last_a});
    end
    release_hold();
    check_value("retain_idle", val_a, last_a);

    // Saturation boundaries, with next_done already high on HOLD entry.
    next_done = 1'b1;
    start_txn(32'h7F8007F8, 1'b0, 1'b0);
    check_value("t6_const", val_c, 16'h7878);
    @(negedge clk);
    check_value("hold_min_one", {valid_a, en_a, busy_a}, 3'b000);
    next_done = 1'b0;

    // in_done held high: only one capture.
    start_txn(32'h10F0_2080, 1'b1, 1'b0);
    release_hold();
    repeat (3) begin
      @(negedge clk);
      check_value("level_no_capture", {busy_a, ovr_a}, 2'b00);
    end
    in_done = 1'b0;
    @(negedge clk);
    start_txn(32'hC4_3B_01_FF, 1'b0, 1'b1);
    check_value("overrun_set", {ovr_a, ovr_b, ovr_c}, 3'b111);
    release_hold();
    check_value("overrun_sticky", ovr_a, 1'b1);

    // Asynchronous reset mid-PROCESS.
    in_data = 32'h40_C0_20_E0;
    in_done = 1'b1;
    @(negedge clk);
    in_done = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_overall = 1'b1;
    #1;
    check_value("async_reset", {val_a, valid_a, en_a, busy_a, ovr_a}, 0);
    @(negedge clk);
    rst_overall = 1'b0;
    @(negedge clk);
    check_value("after_reset", {val_c, busy_c, ovr_c}, 0);
    start_txn(32'h40_C0_20_E0, 1'b0, 1'b0);

    // Edge coinciding with HOLD exit is dropped.
    next_done = 1'b1;
    in_done   = 1'b1;
    @(negedge clk);
    next_done = 1'b0;
    check_value("exit_edge", {busy_a, ovr_a, valid_a}, 3'b010);
    @(negedge clk);
    check_value("exit_no_capture", busy_a, 1'b0);
    in_done = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      start_txn($urandom, 1'b0, 1'b0);
      release_hold();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
